// File: rtl/pixel_tx_if.sv
// Pixel input handshake plus serialised byte/sync outputs of pixel_tx.
interface pixel_tx_if #(
    parameter int PixelBitWidth = 16
);
    logic [PixelBitWidth-1:0] i_data;
    logic                     i_valid;
    logic                     o_ready;
    logic [7:0]               o_data;
    logic                     o_h_sync;
    logic                     o_v_sync;
    logic                     o_underrun;

    modport master (output i_data, i_valid,
                    input  o_ready, o_data, o_h_sync, o_v_sync, o_underrun);
    modport slave  (input  i_data, i_valid,
                    output o_ready, o_data, o_h_sync, o_v_sync, o_underrun);
endinterface

// File: rtl/pixel_tx.sv
// Serialises pixel words into a byte stream framed by v_sync / h_sync.
// Optional sticky underrun flag: define PIXEL_TX_UNDERRUN_EN.
module pixel_tx #(
    parameter int PixelBitWidth = 16,
    parameter int PixelsPerLine = 640,
    parameter int LinesPerFrame = 480,
    parameter int BlankCycles   = 16,
    parameter int VSyncCycles   = 8
) (
    input  logic       p_clk,
    input  logic       RST,
    pixel_tx_if.slave  bus
);
    localparam int B      = PixelBitWidth / 8;
    localparam int PIX_W  = $clog2(PixelsPerLine + 1);
    localparam int LINE_W = $clog2(LinesPerFrame + 1);
    localparam int CNT_W  = $clog2((VSyncCycles > BlankCycles ? VSyncCycles : BlankCycles) + 1);
    localparam int BYTE_W = $clog2(B + 1);

    localparam logic [BYTE_W-1:0] BYTE_LAST  = BYTE_W'(B - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(PixelsPerLine - 1);
    localparam logic [LINE_W-1:0] LINE_ALL   = LINE_W'(LinesPerFrame);
    localparam logic [CNT_W-1:0]  VSYNC_LAST = CNT_W'(VSyncCycles - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BlankCycles - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VSYNC  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_BLANK  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BYTE_W-1:0]        byte_q, byte_d;
    logic [PIX_W-1:0]         pix_q, pix_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic [PixelBitWidth-1:0] buf_q, buf_d;
    logic                     buf_full_q, buf_full_d;
    logic [PixelBitWidth-1:0] sh_q, sh_d;
    logic [7:0]               o_data_q, o_data_d;
    logic                     o_h_sync_q, o_h_sync_d;
    logic                     o_v_sync_q, o_v_sync_d;
    logic                     slot_start, shift_byte, consume, ready, accept;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        pix_d      = pix_q;
        line_d     = line_q;
        slot_start = 1'b0;
        shift_byte = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                end
            end
            S_VSYNC: begin
                if (cnt_q == VSYNC_LAST) begin
                    state_d    = S_ACTIVE;
                    slot_start = 1'b1;
                    byte_d     = '0;
                    pix_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (byte_q != BYTE_LAST) begin
                    byte_d     = byte_q + BYTE_W'(1);
                    shift_byte = 1'b1;
                end else if (pix_q == PIX_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    pix_d   = '0;
                    line_d  = line_q + LINE_W'(1);
                end else begin
                    slot_start = 1'b1;
                    byte_d     = '0;
                    pix_d      = pix_q + PIX_W'(1);
                end
            end
            default: begin
                if (cnt_q != BLANK_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (line_q == LINE_ALL) begin
                    state_d = S_IDLE;
                    line_d  = '0;
                end else begin
                    state_d    = S_ACTIVE;
                    slot_start = 1'b1;
                    byte_d     = '0;
                    pix_d      = '0;
                end
            end
        endcase

        // The buffer drains only into a slot start, which frees it for a new word on the same edge.
        consume    = slot_start & buf_full_q;
        ready      = ~buf_full_q | consume;
        accept     = bus.i_valid & ready;
        buf_d      = accept ? bus.i_data : buf_q;
        buf_full_d = accept | (buf_full_q & ~consume);

        sh_d     = sh_q;
        o_data_d = 8'h00;
        if (slot_start) begin
            sh_d     = consume ? (buf_q >> 8) : '0;
            o_data_d = consume ? buf_q[7:0] : 8'h00;
        end else if (shift_byte) begin
            sh_d     = sh_q >> 8;
            o_data_d = sh_q[7:0];
        end
        o_h_sync_d = (state_d == S_ACTIVE);
        o_v_sync_d = (state_d == S_VSYNC);
    end

    always_ff @(posedge p_clk or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            pix_q      <= '0;
            line_q     <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            sh_q       <= '0;
            o_data_q   <= 8'h00;
            o_h_sync_q <= 1'b0;
            o_v_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            sh_q       <= sh_d;
            o_data_q   <= o_data_d;
            o_h_sync_q <= o_h_sync_d;
            o_v_sync_q <= o_v_sync_d;
        end
    end

    assign bus.o_ready  = ready;
    assign bus.o_data   = o_data_q;
    assign bus.o_h_sync = o_h_sync_q;
    assign bus.o_v_sync = o_v_sync_q;

`ifdef PIXEL_TX_UNDERRUN_EN
    logic underrun_q, underrun_d;

    always_comb underrun_d = underrun_q | (slot_start & ~buf_full_q);

    always_ff @(posedge p_clk or posedge RST) begin
        if (RST) underrun_q <= 1'b0;
        else     underrun_q <= underrun_d;
    end

    assign bus.o_underrun = underrun_q;
`else
    assign bus.o_underrun = 1'b0;
`endif
endmodule
